victim_buffer: RTL and testbench

//  Parametrised fully-associative victim cache: data array plus tags, valid/dirty bits, true-LRU

---
 rtl/victim_buffer_pkg.sv | 13 +
 rtl/victim_buffer_if.sv | 31 +++
 rtl/victim_buffer_lru_ages.sv | 55 +++++
 rtl/victim_buffer.sv | 131 +++++++++++++
 tb/tb_victim_buffer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/victim_buffer_pkg.sv
// Shared types and default sizing for the victim buffer.
package victim_buffer_pkg;

    localparam int VB_WIDTH = 128;
    localparam int VB_DEPTH = 8;
    localparam int VB_TAG_W = 12;

    typedef logic [VB_WIDTH-1:0] lc3b_line;
    typedef logic [VB_TAG_W-1:0] lc3b_vc_tag;

    typedef enum logic {WB_IDLE, WB_PEND} vc_wb_state_t;

endpackage

// File: rtl/victim_buffer_if.sv
// L1 lookup/insert and L2 writeback signals; master is the L1/L2 side, slave is the buffer.
interface victim_buffer_if #(
    parameter int WIDTH = 128,
    parameter int TAG_W = 12
);
    logic             lk_valid;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_resp_valid;
    logic             lk_hit;
    logic             lk_dirty;
    logic [WIDTH-1:0] lk_data;
    logic             ins_valid;
    logic             ins_ready;
    logic [TAG_W-1:0] ins_tag;
    logic             ins_dirty;
    logic [WIDTH-1:0] ins_data;
    logic             wb_valid;
    logic             wb_ready;
    logic [TAG_W-1:0] wb_tag;
    logic [WIDTH-1:0] wb_data;

    modport master (
        output lk_valid, lk_tag, ins_valid, ins_tag, ins_dirty, ins_data, wb_ready,
        input  lk_resp_valid, lk_hit, lk_dirty, lk_data, ins_ready, wb_valid, wb_tag, wb_data
    );

    modport slave (
        input  lk_valid, lk_tag, ins_valid, ins_tag, ins_dirty, ins_data, wb_ready,
        output lk_resp_valid, lk_hit, lk_dirty, lk_data, ins_ready, wb_valid, wb_tag, wb_data
    );
endinterface

// File: rtl/victim_buffer_lru_ages.sv
// True-LRU age permutation (0 = MRU). Invalidation is applied before the touch so a
// same-cycle swap reuses the freed slot.
module vc_lru_ages #(
    parameter  int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             touch,
    input  logic [IDX_W-1:0] touch_idx,
    input  logic             inval,
    input  logic [IDX_W-1:0] inval_idx,
    output logic [IDX_W-1:0] victim_idx
);
    localparam logic [IDX_W-1:0] AGE_MAX = IDX_W'(DEPTH - 1);

    logic [IDX_W-1:0] age     [DEPTH];
    logic [IDX_W-1:0] age_inv [DEPTH];
    logic [IDX_W-1:0] age_nxt [DEPTH];

    always_comb begin
        age_inv = age;
        if (inval) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (IDX_W'(i) == inval_idx)
                    age_inv[i] = AGE_MAX;
                else if (age[i] > age[inval_idx])
                    age_inv[i] = age[i] - 1'b1;
            end
        end
        age_nxt = age_inv;
        if (touch) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (IDX_W'(i) == touch_idx)
                    age_nxt[i] = '0;
                else if (age_inv[i] < age_inv[touch_idx])
                    age_nxt[i] = age_inv[i] + 1'b1;
            end
        end
    end

    always_comb begin
        victim_idx = '0;
        for (int i = 0; i < DEPTH; i++)
            if (age[i] == AGE_MAX) victim_idx = IDX_W'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) age[i] <= IDX_W'(i);
        end else begin
            age <= age_nxt;
        end
    end
endmodule

// File: rtl/victim_buffer.sv
// Fully-associative victim cache between L1 and L2 with a one-deep dirty writeback buffer.
module victim_buffer
    import victim_buffer_pkg::*;
#(
    parameter int WIDTH = VB_WIDTH,
    parameter int DEPTH = VB_DEPTH,
    parameter int TAG_W = VB_TAG_W
) (
    input logic           clk,
    input logic           rst,
    victim_buffer_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [TAG_W-1:0] tags [DEPTH];
    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] dirty;

    logic             hit_any, ins_dup, entry_hit, wb_hit, ins_fire, evict;
    logic [IDX_W-1:0] hit_idx, victim_idx, ins_idx;

    vc_wb_state_t     state;
    logic             wb_valid_r, ins_ready_r;
    logic [TAG_W-1:0] wb_tag_r;
    logic [WIDTH-1:0] wb_data_r;
    logic             resp_valid_r, resp_hit_r, resp_dirty_r;
    logic [WIDTH-1:0] resp_data_r;

    always_comb begin
        hit_any = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && tags[i] == bus.lk_tag) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // A swap may re-insert into the slot being invalidated, so that slot is not a duplicate.
    always_comb begin
        ins_dup = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            if (valid[i] && tags[i] == bus.ins_tag && !(entry_hit && hit_idx == IDX_W'(i)))
                ins_dup = 1'b1;
    end

    assign entry_hit = bus.lk_valid && hit_any;
    assign wb_hit    = bus.lk_valid && wb_valid_r && (wb_tag_r == bus.lk_tag) && !hit_any;
    assign ins_fire  = bus.ins_valid && ins_ready_r;
    assign ins_idx   = entry_hit ? hit_idx : victim_idx;
    assign evict     = ins_fire && !entry_hit && valid[victim_idx] && dirty[victim_idx];

    vc_lru_ages #(.DEPTH(DEPTH)) u_ages (
        .clk        (clk),
        .rst        (rst),
        .touch      (ins_fire),
        .touch_idx  (ins_idx),
        .inval      (entry_hit),
        .inval_idx  (hit_idx),
        .victim_idx (victim_idx)
    );

    always_ff @(posedge clk) begin
        if (ins_fire) begin
            tags[ins_idx] <= bus.ins_tag;
            data[ins_idx] <= bus.ins_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid        <= '0;
            dirty        <= '0;
            resp_valid_r <= 1'b0;
            resp_hit_r   <= 1'b0;
            resp_dirty_r <= 1'b0;
            resp_data_r  <= '0;
        end else begin
            resp_valid_r <= bus.lk_valid;
            if (bus.lk_valid) begin
                resp_hit_r   <= entry_hit || wb_hit;
                resp_dirty_r <= entry_hit && dirty[hit_idx];
                resp_data_r  <= entry_hit ? data[hit_idx] : (wb_hit ? wb_data_r : '0);
            end
            if (entry_hit) valid[hit_idx] <= 1'b0;
            if (ins_fire) begin
                valid[ins_idx] <= 1'b1;
                dirty[ins_idx] <= bus.ins_dirty;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WB_IDLE;
            wb_valid_r  <= 1'b0;
            ins_ready_r <= 1'b1;
            wb_tag_r    <= '0;
            wb_data_r   <= '0;
        end else begin
            case (state)
                WB_IDLE: if (evict) begin
                    state       <= WB_PEND;
                    wb_valid_r  <= 1'b1;
                    ins_ready_r <= 1'b0;
                    wb_tag_r    <= tags[victim_idx];
                    wb_data_r   <= data[victim_idx];
                end
                WB_PEND: if (bus.wb_ready) begin
                    state       <= WB_IDLE;
                    wb_valid_r  <= 1'b0;
                    ins_ready_r <= 1'b1;
                end
                default: state <= WB_IDLE;
            endcase
        end
    end

    assign bus.lk_resp_valid = resp_valid_r;
    assign bus.lk_hit        = resp_hit_r;
    assign bus.lk_dirty      = resp_dirty_r;
    assign bus.lk_data       = resp_data_r;
    assign bus.ins_ready     = ins_ready_r;
    assign bus.wb_valid      = wb_valid_r;
    assign bus.wb_tag        = wb_tag_r;
    assign bus.wb_data       = wb_data_r;

    a_no_dup_insert: assert property (@(posedge clk) disable iff (rst) ins_fire |-> !ins_dup);
endmodule

// File: tb/tb_victim_buffer.sv
// Directed bench for victim_buffer: stimulus pushes expected responses, a monitor pops and compares.
module tb_victim_buffer;
    import victim_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    victim_buffer_if #(.WIDTH(VB_WIDTH), .TAG_W(VB_TAG_W)) bus ();

    victim_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic     hit;
        logic     dirty;
        lc3b_line data;
    } lk_exp_t;

    typedef struct packed {
        lc3b_vc_tag tag;
        lc3b_line   data;
    } wb_exp_t;

    lk_exp_t lk_q[$];
    wb_exp_t wb_q[$];
    int n_pass  = 0;
    int n_total = 0;

    function automatic lc3b_line line_of(input lc3b_vc_tag t);
        return {8{4'hC, t}};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        lk_exp_t e;
        if (bus.lk_resp_valid === 1'b1) begin
            if (lk_q.size() == 0) begin
                check("lk_unexpected", 128'(bus.lk_resp_valid), 128'd0);
            end else begin
                e = lk_q.pop_front();
                check("lk_hit",   128'(bus.lk_hit),   128'(e.hit));
                check("lk_dirty", 128'(bus.lk_dirty), 128'(e.dirty));
                check("lk_data",  128'(bus.lk_data),  128'(e.data));
            end
        end
        if (bus.wb_valid === 1'b1) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected", 128'(bus.wb_valid), 128'd0);
            end else begin
                check("wb_tag",  128'(bus.wb_tag),  128'(wb_q[0].tag));
                check("wb_data", 128'(bus.wb_data), 128'(wb_q[0].data));
                if (bus.wb_ready) void'(wb_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        lk_q.delete();
        wb_q.delete();
        tick();
        rst = 1'b0;
    endtask

    task automatic lookup(input lc3b_vc_tag t, input logic hit, input logic drt);
        bus.lk_valid = 1'b1;
        bus.lk_tag   = t;
        lk_q.push_back({hit, drt, hit ? line_of(t) : lc3b_line'(0)});
        tick();
        bus.lk_valid = 1'b0;
    endtask

    task automatic insert(input lc3b_vc_tag t, input logic drt);
        bus.ins_valid = 1'b1;
        bus.ins_tag   = t;
        bus.ins_dirty = drt;
        bus.ins_data  = line_of(t);
        tick();
        bus.ins_valid = 1'b0;
    endtask

    task automatic swap(input lc3b_vc_tag lt, input logic ldirty, input lc3b_vc_tag it, input logic idirty);
        bus.lk_valid  = 1'b1;
        bus.lk_tag    = lt;
        lk_q.push_back({1'b1, ldirty, line_of(lt)});
        bus.ins_valid = 1'b1;
        bus.ins_tag   = it;
        bus.ins_dirty = idirty;
        bus.ins_data  = line_of(it);
        tick();
        bus.lk_valid  = 1'b0;
        bus.ins_valid = 1'b0;
    endtask

    task automatic fill(input logic drt);
        for (int t = 1; t <= 8; t++) insert(lc3b_vc_tag'(t), drt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.lk_valid  = 1'b0;
        bus.lk_tag    = '0;
        bus.ins_valid = 1'b0;
        bus.ins_tag   = '0;
        bus.ins_dirty = 1'b0;
        bus.ins_data  = '0;
        bus.wb_ready  = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // reset state and a miss on an empty buffer
        check("rst_lk_resp_valid", 128'(bus.lk_resp_valid), 128'd0);
        check("rst_lk_hit",        128'(bus.lk_hit),        128'd0);
        check("rst_lk_dirty",      128'(bus.lk_dirty),      128'd0);
        check("rst_lk_data",       128'(bus.lk_data),       128'd0);
        check("rst_wb_valid",      128'(bus.wb_valid),      128'd0);
        check("rst_wb_tag",        128'(bus.wb_tag),        128'd0);
        check("rst_wb_data",       128'(bus.wb_data),       128'd0);
        check("rst_ins_ready",     128'(bus.ins_ready),     128'd1);
        lookup(12'h123, 1'b0, 1'b0);

        // clean fill, hit returns and invalidates
        fill(1'b0);
        lookup(12'h003, 1'b1, 1'b0);
        lookup(12'h003, 1'b0, 1'b0);

        // dirty eviction with L2 back-pressure
        do_reset();
        fill(1'b1);
        bus.wb_ready = 1'b0;
        wb_q.push_back({12'h001, line_of(12'h001)});
        insert(12'h009, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check("pend_ins_ready", 128'(bus.ins_ready), 128'd0);
            check("pend_wb_valid",  128'(bus.wb_valid),  128'd1);
            insert(12'h00A, 1'b1);
        end
        bus.wb_ready = 1'b1;
        tick();
        check("idle_ins_ready", 128'(bus.ins_ready), 128'd1);
        check("idle_wb_valid",  128'(bus.wb_valid),  128'd0);
        lookup(12'h00A, 1'b0, 1'b0);
        lookup(12'h009, 1'b1, 1'b1);
        lookup(12'h001, 1'b0, 1'b0);

        // swap: hit and insert on the same edge, no eviction
        do_reset();
        fill(1'b1);
        swap(12'h005, 1'b1, 12'h0A0, 1'b0);
        check("swap_wb_valid",  128'(bus.wb_valid),  128'd0);
        check("swap_ins_ready", 128'(bus.ins_ready), 128'd1);
        lookup(12'h0A0, 1'b1, 1'b0);
        lookup(12'h001, 1'b1, 1'b1);

        // freed entry absorbs an insert; next insert evicts the LRU line
        do_reset();
        fill(1'b1);
        lookup(12'h002, 1'b1, 1'b1);
        insert(12'h0B0, 1'b1);
        check("free_wb_valid", 128'(bus.wb_valid), 128'd0);
        wb_q.push_back({12'h001, line_of(12'h001)});
        insert(12'h0C0, 1'b1);
        check("lru_wb_valid", 128'(bus.wb_valid), 128'd1);
        tick();
        check("lru_wb_done", 128'(bus.wb_valid), 128'd0);
        for (int t = 3; t <= 8; t++) lookup(lc3b_vc_tag'(t), 1'b1, 1'b1);
        lookup(12'h001, 1'b0, 1'b0);
        lookup(12'h0B0, 1'b1, 1'b1);
        lookup(12'h0C0, 1'b1, 1'b1);

        // hit in the writeback buffer, then reset discards it
        do_reset();
        fill(1'b1);
        bus.wb_ready = 1'b0;
        wb_q.push_back({12'h001, line_of(12'h001)});
        insert(12'h009, 1'b1);
        lookup(12'h001, 1'b1, 1'b0);
        do_reset();
        bus.wb_ready = 1'b1;
        check("rst2_wb_valid",  128'(bus.wb_valid),  128'd0);
        check("rst2_ins_ready", 128'(bus.ins_ready), 128'd1);
        lookup(12'h002, 1'b0, 1'b0);

        tick();
        tick();
        check("lk_q_drained", 128'(lk_q.size()), 128'd0);
        check("wb_q_drained", 128'(wb_q.size()), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
